dmem_responder: RTL and testbench

- Data-memory responder for the ARM core's load/store port, with a valid/ready request channel and a valid/ready response channel.
- Sits between the core's memory-stage initiator and a word-addressed RAM array, and adds programmable wait states.
- Supports byte-enabled writes and flags misaligned or out-of-range accesses.
- Lets multi-cycle and stalling core variants run against a realistic-latency memory instead of a combinational one.

---
 rtl/dmem_responder.sv | 180 ++++++++++++++++++
 tb/tb_dmem_responder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with programmable wait states and fault flagging
module dmem_responder #(
   parameter int DEPTH   = 64,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam bit ZERO_LAT = (LATENCY == 0);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        live_q;

   logic        lat_write;
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;
   logic [3:0]  lat_be;

   logic        req_fire;
   logic        rsp_fire;
   logic        enter_resp;

   logic        op_write;
   logic [31:0] op_addr;
   logic [31:0] op_wdata;
   logic [3:0]  op_be;
   logic        op_err;
   logic [AW-1:0] op_idx;

   logic [31:0] ram [DEPTH];
   logic [31:0] ram_word;
   logic [31:0] merged;

   assign req_fire = req_valid & req_ready;
   assign rsp_fire = rsp_valid & rsp_ready;

   // live_q keeps req_ready low while reset is held and for the edge it is released on
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         live_q <= 1'b0;
      end else begin
         live_q <= 1'b1;
      end
   end

   // state and wait-counter registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // next-state, handshake outputs and the "entering RESP" strobe
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      req_ready  = 1'b0;
      rsp_valid  = 1'b0;
      enter_resp = 1'b0;
      case (state_q)
         S_IDLE: begin
            req_ready = live_q;
            if (req_valid && live_q) begin
               if (ZERO_LAT) begin
                  state_d    = S_RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = 4'(LATENCY - 1);
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d    = S_RESP;
               enter_resp = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // capture the request on acceptance; used when the access completes from WAIT
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lat_write <= 1'b0;
         lat_addr  <= 32'd0;
         lat_wdata <= 32'd0;
         lat_be    <= 4'd0;
      end else if (req_fire) begin
         lat_write <= req_write;
         lat_addr  <= req_addr;
         lat_wdata <= req_wdata;
         lat_be    <= req_be;
      end
   end

   // with zero latency the access completes on the acceptance edge, so use the live request
   always_comb begin
      op_write = lat_write;
      op_addr  = lat_addr;
      op_wdata = lat_wdata;
      op_be    = lat_be;
      if (state_q == S_IDLE) begin
         op_write = req_write;
         op_addr  = req_addr;
         op_wdata = req_wdata;
         op_be    = req_be;
      end
   end

   assign op_err   = (op_addr[1:0] != 2'b00) || ({2'b00, op_addr[31:2]} >= 32'(DEPTH));
   assign op_idx   = op_addr[AW+1:2];
   assign ram_word = ram[op_idx];

   // byte-lane merge of store data over the current word
   always_comb begin
      merged = ram_word;
      for (int i = 0; i < 4; i++) begin
         if (op_be[i]) begin
            merged[8*i +: 8] = op_wdata[8*i +: 8];
         end
      end
   end

   // RAM array is deliberately not reset; stores commit only on a fault-free entry to RESP
   always_ff @(posedge clk) begin
      if (enter_resp && op_write && !op_err) begin
         ram[op_idx] <= merged;
      end
   end

   // response payload: loaded when entering RESP, held until the response handshake
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_rdata <= 32'd0;
         rsp_err   <= 1'b0;
      end else if (enter_resp) begin
         rsp_err   <= op_err;
         rsp_rdata <= (op_err || op_write) ? 32'd0 : ram_word;
      end else if (rsp_fire) begin
         rsp_rdata <= 32'd0;
         rsp_err   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder (LATENCY=2 and LATENCY=0 instances)
module tb_dmem_responder;

   localparam int DEPTH = 64;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_write = 1'b0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic [3:0]  req_be = 4'd0;
   logic        rsp_ready = 1'b0;
   int          sel = 0;

   logic        va, vb;
   logic        rr_a, rv_a, re_a, rr_b, rv_b, re_b;
   logic [31:0] rd_a, rd_b;
   logic        req_ready_m, rsp_valid_m, rsp_err_m;
   logic [31:0] rsp_rdata_m;

   int errors = 0;
   int checks = 0;

   logic [31:0] mem   [2][DEPTH];
   bit          known [2][DEPTH];
   time         prev_t;
   bit          have_prev;

   always #5 clk = ~clk;

   assign va = req_valid && (sel == 0);
   assign vb = req_valid && (sel != 0);

   assign req_ready_m = (sel != 0) ? rr_b : rr_a;
   assign rsp_valid_m = (sel != 0) ? rv_b : rv_a;
   assign rsp_err_m   = (sel != 0) ? re_b : re_a;
   assign rsp_rdata_m = (sel != 0) ? rd_b : rd_a;

   dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_lat2 (
      .clk(clk), .reset(reset),
      .req_valid(va), .req_ready(rr_a), .req_write(req_write), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(rv_a), .rsp_ready(rsp_ready), .rsp_rdata(rd_a), .rsp_err(re_a)
   );

   dmem_responder #(.DEPTH(DEPTH), .LATENCY(0)) u_lat0 (
      .clk(clk), .reset(reset),
      .req_valid(vb), .req_ready(rr_b), .req_write(req_write), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(rv_b), .rsp_ready(rsp_ready), .rsp_rdata(rd_b), .rsp_err(re_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int cur_lat();
      return (sel != 0) ? 0 : 2;
   endfunction

   // reset-value checks used right after an asynchronous reset assertion
   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req_ready"}, req_ready_m, 0);
      chk({tag, "_rsp_valid"}, rsp_valid_m, 0);
      chk({tag, "_rsp_rdata"}, rsp_rdata_m, 0);
      chk({tag, "_rsp_err"},   rsp_err_m, 0);
   endtask

   // one transaction; caller is at a negedge. abort: 0 none, 1 reset in WAIT, 2 reset in RESP
   task automatic txn(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                      input int hold, input int abort, input bit b2b);
      bit          exp_err;
      int          idx;
      int          k;
      int          lat;
      bit          rd_known;
      logic [31:0] exp_rd;
      logic [31:0] cap_rd;
      logic        cap_err;
      time         acc_t;
      lat      = cur_lat();
      exp_err  = (a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH));
      idx      = exp_err ? 0 : int'(a[31:2]);
      rd_known = w || exp_err || known[sel][idx];
      exp_rd   = (w || exp_err) ? 32'd0 : mem[sel][idx];

      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      req_be    = be;
      rsp_ready = (hold == 0) && (abort == 0);
      chk("req_ready_idle", req_ready_m, 1);
      @(posedge clk);
      acc_t = $time;
      @(negedge clk);
      req_valid = 1'b0;
      req_addr  = $urandom;
      req_wdata = $urandom;
      if (b2b && have_prev) chk("throughput", 32'(acc_t - prev_t), 32'(10 * (lat + 2)));
      prev_t    = acc_t;
      have_prev = 1'b1;

      if (abort == 1) begin
         reset = 1'b1;
         #1;
         chk_reset_outputs("abort_wait");
         @(negedge clk);
         reset = 1'b0;
         @(negedge clk);
         chk("abort_wait_ready", req_ready_m, 1);
         return;
      end

      k = 0;
      while (rsp_valid_m !== 1'b1 && k < 40) begin
         chk("req_ready_wait", req_ready_m, 0);
         @(negedge clk);
         k++;
      end
      chk("latency", k, lat);

      if (w && !exp_err) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[sel][idx][8*i +: 8] = d[8*i +: 8];
         end
         if (be == 4'hF) known[sel][idx] = 1'b1;
      end

      chk("rsp_err", rsp_err_m, exp_err);
      if (rd_known) chk("rsp_rdata", rsp_rdata_m, exp_rd);
      chk("req_ready_resp", req_ready_m, 0);
      cap_rd  = rsp_rdata_m;
      cap_err = rsp_err_m;

      if (abort == 2) begin
         reset = 1'b1;
         #1;
         chk_reset_outputs("abort_resp");
         @(negedge clk);
         reset = 1'b0;
         @(negedge clk);
         chk("abort_resp_ready", req_ready_m, 1);
         return;
      end

      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_valid", rsp_valid_m, 1);
         chk("hold_rdata", rsp_rdata_m, cap_rd);
         chk("hold_err", rsp_err_m, cap_err);
         chk("hold_req_ready", req_ready_m, 0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("post_valid", rsp_valid_m, 0);
      chk("post_rdata", rsp_rdata_m, 0);
      chk("post_err", rsp_err_m, 0);
      chk("post_req_ready", req_ready_m, 1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      bit          w;
      logic [31:0] a;
      logic [3:0]  be;
      int          r;
      int          wi;

      have_prev = 1'b0;
      repeat (2) @(negedge clk);
      chk_reset_outputs("reset_a");
      sel = 1;
      chk_reset_outputs("reset_b");
      sel = 0;
      reset = 1'b0;
      @(negedge clk);
      chk("ready_after_reset_a", rr_a, 1);
      chk("ready_after_reset_b", rr_b, 1);

      // 1: store then load, LATENCY=2
      txn(1, 32'h60, 32'h0000_0007, 4'hF, 0, 0, 0);
      txn(0, 32'h60, 32'h0, 4'h0, 0, 0, 0);
      // 2: byte-enable merge, then a be=0000 store leaves the word alone
      txn(1, 32'h10, 32'hAABB_CCDD, 4'hF, 0, 0, 0);
      txn(1, 32'h10, 32'h1122_3344, 4'b0101, 0, 0, 0);
      txn(0, 32'h10, 32'h0, 4'h0, 0, 0, 0);
      txn(1, 32'h10, 32'hFFFF_FFFF, 4'b0000, 0, 0, 0);
      txn(0, 32'h10, 32'h0, 4'h0, 0, 0, 0);
      // 3: misaligned and out-of-range faults
      txn(1, 32'hFC, 32'h0BAD_F00D, 4'hF, 0, 0, 0);
      txn(0, 32'h61, 32'h0, 4'h0, 0, 0, 0);
      txn(1, 32'h100, 32'h1234_5678, 4'hF, 0, 0, 0);
      txn(1, 32'h8000_00FC, 32'h1234_5678, 4'hF, 0, 0, 0);
      txn(0, 32'hFC, 32'h0, 4'h0, 0, 0, 0);
      // 4: response backpressure
      txn(0, 32'h60, 32'h0, 4'h0, 5, 0, 0);
      // 5: reset during WAIT drops the store; reset during RESP keeps it
      txn(1, 32'h20, 32'h0000_0005, 4'hF, 0, 0, 0);
      txn(1, 32'h20, 32'hDEAD_BEEF, 4'hF, 0, 1, 0);
      txn(0, 32'h20, 32'h0, 4'h0, 0, 0, 0);
      txn(1, 32'h24, 32'hCAFE_0124, 4'hF, 0, 2, 0);
      txn(0, 32'h24, 32'h0, 4'h0, 0, 0, 0);

      // 6: LATENCY=0 back-to-back loads
      sel = 1;
      for (int i = 0; i < 4; i++) txn(1, 32'(i * 4), 32'hC0DE_0000 + 32'(i), 4'hF, 0, 0, 0);
      have_prev = 1'b0;
      for (int i = 0; i < 4; i++) txn(0, 32'(i * 4), 32'h0, 4'h0, 0, 0, 1);
      sel = 0;
      have_prev = 1'b0;
      for (int i = 0; i < 3; i++) txn(0, 32'h60, 32'h0, 4'h0, 0, 0, 1);

      // randomized traffic on both instances
      for (int n = 0; n < 80; n++) begin
         sel = int'($urandom_range(0, 1));
         r   = int'($urandom_range(0, 9));
         wi  = int'($urandom_range(0, DEPTH - 1));
         w   = $urandom_range(0, 1) == 1;
         be  = 4'($urandom);
         if (r == 0)      a = {24'd0, 6'(wi), 2'($urandom_range(1, 3))};
         else if (r == 1) a = 32'($urandom_range(DEPTH, 4095)) << 2;
         else if (r == 2) a = {1'b1, 23'($urandom), 6'(wi), 2'b00};
         else             a = {24'd0, 6'(wi), 2'b00};
         if (r >= 3 && !known[sel][wi]) begin
            w  = 1'b1;
            be = 4'hF;
         end
         txn(w, a, $urandom, be, int'($urandom_range(0, 2)), 0, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
